// File: rtl/pc_unit.sv
// Program counter with optional hardware return-address stack.
// Define PC_RET_STACK_EN to build the stack and full call/ret behaviour.
module pc_unit #(
    parameter int unsigned      WIDTH        = 16,
    parameter int unsigned      DEPTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             load,
    input  logic [WIDTH-1:0] load_addr,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic             stk_empty,
    output logic             stk_full,
    output logic             stk_err
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_nxt;

    assign pc_inc = pc + ONE;

`ifdef PC_RET_STACK_EN
    localparam int unsigned     AW       = $clog2(DEPTH);
    localparam int unsigned     CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic             err, err_nxt;
    logic             push;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    push_idx;
    logic [WIDTH-1:0] stack [DEPTH];

    // Top of stack sits at count-1; the next free slot is at count.
    assign top_idx  = AW'(count - CNT_ONE);
    assign push_idx = AW'(count);

    always_comb begin
        pc_nxt    = pc;
        state_nxt = state;
        count_nxt = count;
        err_nxt   = err;
        push      = 1'b0;
        if (!stall) begin
            if (ret) begin
                if (state != EMPTY) begin
                    pc_nxt    = stack[top_idx];
                    count_nxt = count - CNT_ONE;
                    state_nxt = (count == CNT_ONE) ? EMPTY : PARTIAL;
                end else begin
                    pc_nxt  = pc_inc;
                    err_nxt = 1'b1;
                end
            end else if (call) begin
                pc_nxt = load_addr;
                if (state != FULL) begin
                    push      = 1'b1;
                    count_nxt = count + CNT_ONE;
                    state_nxt = (count == CNT_LAST) ? FULL : PARTIAL;
                end else begin
                    err_nxt = 1'b1;
                end
            end else if (load) begin
                pc_nxt = load_addr;
            end else begin
                pc_nxt = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            count <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            err   <= err_nxt;
        end
    end

    // Entries are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[push_idx] <= pc_inc;
        end
    end

    assign stk_empty = (state == EMPTY);
    assign stk_full  = (state == FULL);
    assign stk_err   = err;
`else
    logic ret_unused;

    // Without the stack, ret degenerates to increment and call to load.
    assign ret_unused = ret;

    always_comb begin
        pc_nxt = pc;
        if (!stall) begin
            if (load || call) begin
                pc_nxt = load_addr;
            end else begin
                pc_nxt = pc_inc;
            end
        end
    end

    assign stk_empty = 1'b1;
    assign stk_full  = 1'b0;
    assign stk_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_pc_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_addr = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [15:0] pc;
    logic        stk_empty, stk_full, stk_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        stall, load, call, ret;
        logic [15:0] addr;
        logic [15:0] exp_pc;
        logic        exp_empty, exp_full, exp_err;
    } vec_t;

    vec_t tbl[11];

    // Reference model: plain queue used as a LIFO.
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_err;

    pc_unit #(.WIDTH(16), .DEPTH(DEPTH), .RESET_VECTOR(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .load(load),
        .load_addr(load_addr), .call(call), .ret(ret), .pc(pc),
        .stk_empty(stk_empty), .stk_full(stk_full), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic s, input logic l, input logic c, input logic r,
                                input logic [15:0] a, input logic [15:0] p);
        vec_t v;
        v.stall = s; v.load = l; v.call = c; v.ret = r; v.addr = a;
        v.exp_pc = p; v.exp_empty = 1'b1; v.exp_full = 1'b0; v.exp_err = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] ep,
                         input logic ee, input logic ef, input logic er);
        vectors++;
        if (pc !== ep || stk_empty !== ee || stk_full !== ef || stk_err !== er) begin
            miscompares++;
            $display("FAIL %s: pc=%h empty=%b full=%b err=%b, expected pc=%h empty=%b full=%b err=%b",
                     name, pc, stk_empty, stk_full, stk_err, ep, ee, ef, er);
        end
    endtask

    task automatic step(input logic s, input logic l, input logic c, input logic r,
                        input logic [15:0] a);
        stall = s; load = l; call = c; ret = r; load_addr = a;
        @(posedge clk);
        #1;
        stall = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    // Asserts reset between edges, checks the asynchronous effect, releases
    // on the falling edge so the next rising edge is the first action.
    task automatic do_reset(input string name);
        stall = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
        rst_n = 1'b0;
        #2;
        check(name, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic model_step(input logic s, input logic l, input logic c, input logic r,
                              input logic [15:0] a);
        if (s) return;
`ifdef PC_RET_STACK_EN
        if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = m_pc + 16'd1; m_err = 1'b1; end
        end else if (c) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 16'd1);
            else m_err = 1'b1;
            m_pc = a;
        end else if (l) m_pc = a;
        else m_pc = m_pc + 16'd1;
`else
        if (l || c) m_pc = a;
        else m_pc = m_pc + 16'd1;
`endif
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 16'h0000, 16'h0001);
        tbl[1]  = mk(0, 0, 0, 0, 16'h0000, 16'h0002);
        tbl[2]  = mk(0, 0, 0, 0, 16'h0000, 16'h0003);
        tbl[3]  = mk(0, 1, 0, 0, 16'h0010, 16'h0010);
        tbl[4]  = mk(0, 1, 0, 0, 16'h1234, 16'h1234);
        tbl[5]  = mk(1, 0, 0, 0, 16'h0000, 16'h1234);
        tbl[6]  = mk(1, 1, 0, 0, 16'h5555, 16'h1234);
        tbl[7]  = mk(0, 1, 0, 0, 16'hFFFE, 16'hFFFE);
        tbl[8]  = mk(0, 0, 0, 0, 16'h0000, 16'hFFFF);
        tbl[9]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000);
        tbl[10] = mk(0, 1, 0, 0, 16'h0300, 16'h0300);

        #3;
        check("reset_state", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].stall, tbl[i].load, tbl[i].call, tbl[i].ret, tbl[i].addr);
            check($sformatf("table_%0d", i), tbl[i].exp_pc,
                  tbl[i].exp_empty, tbl[i].exp_full, tbl[i].exp_err);
        end

        step(0, 0, 0, 0, 16'h0);
        check("count_0301", 16'h0301, 1'b1, 1'b0, 1'b0);
        do_reset("async_reset_mid_count");
        step(0, 0, 0, 0, 16'h0);
        check("first_after_reset", 16'h0001, 1'b1, 1'b0, 1'b0);

`ifdef PC_RET_STACK_EN
        step(0, 1, 0, 0, 16'h0100);
        step(0, 0, 1, 0, 16'h0800);
        check("call_0800", 16'h0800, 1'b0, 1'b0, 1'b0);
        step(0, 0, 0, 0, 16'h0);
        step(1, 0, 0, 1, 16'h0);
        check("stall_holds_stack", 16'h0801, 1'b0, 1'b0, 1'b0);
        step(0, 0, 0, 0, 16'h0);
        check("inc_0802", 16'h0802, 1'b0, 1'b0, 1'b0);
        step(0, 0, 0, 1, 16'h0);
        check("ret_0101", 16'h0101, 1'b1, 1'b0, 1'b0);

        step(0, 1, 0, 0, 16'h0010);
        step(0, 0, 1, 0, 16'h0020);
        step(0, 0, 1, 0, 16'h0030);
        check("nest_2", 16'h0030, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1, 0, 16'h0040);
        step(0, 0, 1, 0, 16'h0050);
        check("nest_full", 16'h0050, 1'b0, 1'b1, 1'b0);
        step(0, 0, 1, 0, 16'h0900);
        check("overflow", 16'h0900, 1'b0, 1'b1, 1'b1);
        step(0, 0, 0, 1, 16'h0);
        check("ret_0041", 16'h0041, 1'b0, 1'b0, 1'b1);
        step(0, 0, 0, 1, 16'h0);
        check("ret_0031", 16'h0031, 1'b0, 1'b0, 1'b1);
        step(0, 0, 0, 1, 16'h0);
        check("ret_0021", 16'h0021, 1'b0, 1'b0, 1'b1);
        step(0, 0, 0, 1, 16'h0);
        check("ret_0011", 16'h0011, 1'b1, 1'b0, 1'b1);

        do_reset("reset_clears_err");
        step(0, 1, 0, 0, 16'h0050);
        step(0, 0, 0, 1, 16'h0);
        check("underflow", 16'h0051, 1'b1, 1'b0, 1'b1);
        step(0, 0, 0, 0, 16'h0);
        check("err_sticky", 16'h0052, 1'b1, 1'b0, 1'b1);
        do_reset("reset_after_err");

        step(0, 1, 0, 0, 16'hFFFF);
        step(0, 0, 1, 0, 16'h0200);
        check("call_at_ffff", 16'h0200, 1'b0, 1'b0, 1'b0);
        step(0, 0, 0, 1, 16'h0);
        check("ret_wraps_0000", 16'h0000, 1'b1, 1'b0, 1'b0);
        step(0, 1, 0, 0, 16'h0400);
        step(0, 0, 1, 0, 16'h0700);
        step(0, 0, 0, 1, 16'h0);
        check("call_ret_back_to_back", 16'h0401, 1'b1, 1'b0, 1'b0);
        step(0, 0, 1, 1, 16'h0600);
        check("ret_beats_call", 16'h0402, 1'b1, 1'b0, 1'b1);
`else
        step(0, 0, 1, 0, 16'h0300);
        check("call_as_load", 16'h0300, 1'b1, 1'b0, 1'b0);
        step(0, 0, 0, 1, 16'h0);
        check("ret_as_inc", 16'h0301, 1'b1, 1'b0, 1'b0);
        step(0, 0, 0, 1, 16'h0);
        check("ret_no_err", 16'h0302, 1'b1, 1'b0, 1'b0);
        step(1, 0, 1, 0, 16'h0900);
        check("stall_over_call", 16'h0302, 1'b1, 1'b0, 1'b0);
`endif

        do_reset("reset_before_random");
        m_pc = 16'h0000;
        m_stk.delete();
        m_err = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic s, l, c, r;
            logic [15:0] a;
            s = ($urandom_range(0, 7) == 0);
            l = ($urandom_range(0, 5) == 0);
            c = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 4) == 0);
            a = 16'($urandom);
            if ($urandom_range(0, 15) == 0) a = 16'hFFFF;
`ifndef PC_RET_STACK_EN
            if (c) r = 1'b0;
`endif
            step(s, l, c, r, a);
            model_step(s, l, c, r, a);
`ifdef PC_RET_STACK_EN
            check($sformatf("random_%0d", n), m_pc, m_stk.size() == 0,
                  m_stk.size() == DEPTH, m_err);
`else
            check($sformatf("random_%0d", n), m_pc, 1'b1, 1'b0, 1'b0);
`endif
            if (n == 300) begin
                do_reset("reset_mid_random");
                m_pc = 16'h0000;
                m_stk.delete();
                m_err = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
